// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses, exception codes and Status/Cause bit positions.
package cp0_regfile_pkg;

  // {rd[4:0], sel[2:0]}
  localparam logic [7:0] AddrBadVAddr = 8'h40;
  localparam logic [7:0] AddrCount    = 8'h48;
  localparam logic [7:0] AddrCompare  = 8'h58;
  localparam logic [7:0] AddrStatus   = 8'h60;
  localparam logic [7:0] AddrCause    = 8'h68;
  localparam logic [7:0] AddrEpc      = 8'h70;

  localparam logic [4:0] ExcInt  = 5'h00;
  localparam logic [4:0] ExcAdel = 5'h04;
  localparam logic [4:0] ExcAdes = 5'h05;
  localparam logic [4:0] ExcSys  = 5'h08;
  localparam logic [4:0] ExcBp   = 5'h09;
  localparam logic [4:0] ExcRi   = 5'h0A;
  localparam logic [4:0] ExcOv   = 5'h0C;

  localparam int unsigned StatusBev   = 22;
  localparam int unsigned StatusImLo  = 8;
  localparam int unsigned StatusExl   = 1;
  localparam int unsigned StatusIe    = 0;
  localparam int unsigned CauseBd     = 31;
  localparam int unsigned CauseTi     = 30;
  localparam int unsigned CauseIpLo   = 8;
  localparam int unsigned CauseExcLo  = 2;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: divided free-running counter plus sticky timer interrupt flag.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = count_q;
    tick_d    = ~tick_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
      tick_d  = 1'b0;
    end else if (COUNT_DIV == 1 || tick_q) begin
      count_d = count_q + 32'd1;
    end
    // A Compare write clears TI even if the match fires in the same cycle.
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: exception commit, ERET, MTC0/MFC0 access and interrupt request.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2,
  parameter logic [31:0] EPC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_ex,
  input  logic        wb_bd,
  input  logic [4:0]  wb_excode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        eret_flush,
  input  logic [5:0]  ext_int_in,
  input  logic [7:0]  cp0_addr,
  output logic [31:0] cp0_rdata,
  input  logic        mtc0_we,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic        has_int
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [7:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] count, compare;
  logic        ti;
  logic        wr;

  // An exception in WB squashes any MTC0 committing alongside it.
  assign wr = mtc0_we & ~wb_ex;

  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .count_we_i  (wr && cp0_addr == AddrCount),
    .compare_we_i(wr && cp0_addr == AddrCompare),
    .wdata_i     (cp0_wdata),
    .count_o     (count),
    .compare_o   (compare),
    .ti_o        (ti)
  );

  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    exc_d  = exc_q;
    epc_d  = epc_q;
    badv_d = badv_q;
    ip_d   = {ext_int_in[5] | ti, ext_int_in[4:0], ip_q[1:0]};
    if (wb_ex) begin
      exl_d = 1'b1;
      exc_d = wb_excode;
      if (!exl_q) begin
        bd_d  = wb_bd;
        epc_d = wb_bd ? wb_pc - 32'd4 : wb_pc;
      end
      if (wb_excode == ExcAdel || wb_excode == ExcAdes) badv_d = wb_badvaddr;
    end else begin
      if (wr && cp0_addr == AddrStatus) begin
        im_d  = cp0_wdata[15:8];
        ie_d  = cp0_wdata[StatusIe];
        exl_d = cp0_wdata[StatusExl];
      end
      if (eret_flush) exl_d = 1'b0;
      if (wr && cp0_addr == AddrCause) ip_d[1:0] = cp0_wdata[9:8];
      if (wr && cp0_addr == AddrEpc) epc_d = cp0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q   <= 8'd0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= 8'd0;
      exc_q  <= 5'd0;
      epc_q  <= EPC_RESET;
      badv_q <= 32'd0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ip_q   <= ip_d;
      exc_q  <= exc_d;
      epc_q  <= epc_d;
      badv_q <= badv_d;
    end
  end

  always_comb begin
    cp0_status                          = 32'd0;
    cp0_status[StatusBev]               = 1'b1;
    cp0_status[StatusImLo+:8]           = im_q;
    cp0_status[StatusExl]               = exl_q;
    cp0_status[StatusIe]                = ie_q;
    cp0_cause                           = 32'd0;
    cp0_cause[CauseBd]                  = bd_q;
    cp0_cause[CauseTi]                  = ti;
    cp0_cause[CauseIpLo+:8]             = ip_q;
    cp0_cause[CauseExcLo+:5]            = exc_q;
  end

  assign cp0_epc = epc_q;
  assign has_int = (|(ip_q & im_q)) & ie_q & ~exl_q;

  always_comb begin
    case (cp0_addr)
      AddrBadVAddr: cp0_rdata = badv_q;
      AddrCount:    cp0_rdata = count;
      AddrCompare:  cp0_rdata = compare;
      AddrStatus:   cp0_rdata = cp0_status;
      AddrCause:    cp0_rdata = cp0_cause;
      AddrEpc:      cp0_rdata = epc_q;
      default:      cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios then random traffic against a reference model.
module tb_cp0_regfile;

  localparam int unsigned CountDiv = 2;
  localparam logic [31:0] EpcReset = 32'hBFC0_0000;

  logic        clk, reset;
  logic        wb_ex, wb_bd, eret_flush, mtc0_we, has_int;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, cp0_wdata, cp0_rdata, cp0_epc, cp0_status, cp0_cause;
  logic [5:0]  ext_int_in;
  logic [7:0]  cp0_addr;

  cp0_regfile #(
    .COUNT_DIV(CountDiv),
    .EPC_RESET(EpcReset)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_ex      (wb_ex),
    .wb_bd      (wb_bd),
    .wb_excode  (wb_excode),
    .wb_pc      (wb_pc),
    .wb_badvaddr(wb_badvaddr),
    .eret_flush (eret_flush),
    .ext_int_in (ext_int_in),
    .cp0_addr   (cp0_addr),
    .cp0_rdata  (cp0_rdata),
    .mtc0_we    (mtc0_we),
    .cp0_wdata  (cp0_wdata),
    .cp0_epc    (cp0_epc),
    .cp0_status (cp0_status),
    .cp0_cause  (cp0_cause),
    .has_int    (has_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural register fields.
  logic [31:0] m_badv, m_count, m_compare, m_epc;
  int unsigned m_since;  // cycles since Count was last loaded
  logic        m_ti, m_ie, m_exl, m_bd;
  logic [7:0]  m_im, m_ip;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_status_word();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_cause_word();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 8) | (32'(m_exc) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40:   return m_badv;
      8'h48:   return m_count;
      8'h58:   return m_compare;
      8'h60:   return m_status_word();
      8'h68:   return m_cause_word();
      8'h70:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_badv = 0; m_count = 0; m_compare = 0; m_epc = EpcReset; m_since = 0;
    m_ti = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_ip = 0; m_exc = 0;
  endtask

  // Applies one clock of architectural rules using the inputs present at the edge.
  task automatic model_update();
    bit          ex, er, wr;
    logic [31:0] n_count, n_compare, n_epc, n_badv;
    int unsigned n_since;
    logic        n_ti, n_ie, n_exl, n_bd;
    logic [7:0]  n_im, n_ip;
    logic [4:0]  n_exc;
    ex = wb_ex; er = eret_flush && !ex; wr = mtc0_we && !ex;
    n_count = m_count; n_compare = m_compare; n_epc = m_epc; n_badv = m_badv;
    n_ie = m_ie; n_exl = m_exl; n_bd = m_bd; n_im = m_im; n_exc = m_exc;
    if (wr && cp0_addr == 8'h48) begin
      n_count = cp0_wdata; n_since = 0;
    end else begin
      if (CountDiv == 1 || (m_since % 2) == 1) n_count = m_count + 1;
      n_since = m_since + 1;
    end
    if (wr && cp0_addr == 8'h58) begin
      n_compare = cp0_wdata; n_ti = 0;
    end else begin
      n_ti = (m_count == m_compare) ? 1'b1 : m_ti;
    end
    n_ip = {ext_int_in[5] | m_ti, ext_int_in[4:0], m_ip[1:0]};
    if (wr && cp0_addr == 8'h68) n_ip[1:0] = cp0_wdata[9:8];
    if (ex) begin
      n_exl = 1; n_exc = wb_excode;
      if (!m_exl) begin
        n_bd  = wb_bd;
        n_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
      end
      if (wb_excode == 5'h04 || wb_excode == 5'h05) n_badv = wb_badvaddr;
    end else begin
      if (wr && cp0_addr == 8'h60) begin
        n_im = cp0_wdata[15:8]; n_ie = cp0_wdata[0]; n_exl = cp0_wdata[1];
      end
      if (er) n_exl = 0;
      if (wr && cp0_addr == 8'h70) n_epc = cp0_wdata;
    end
    m_count = n_count; m_compare = n_compare; m_epc = n_epc; m_badv = n_badv; m_since = n_since;
    m_ti = n_ti; m_ie = n_ie; m_exl = n_exl; m_bd = n_bd; m_im = n_im; m_ip = n_ip; m_exc = n_exc;
  endtask

  task automatic check_outputs();
    check_eq("status", cp0_status, m_status_word());
    check_eq("cause", cp0_cause, m_cause_word());
    check_eq("epc", cp0_epc, m_epc);
    check_eq("has_int", {31'd0, has_int},
             {31'd0, (|(m_ip & m_im)) & m_ie & ~m_exl});
  endtask

  task automatic idle_inputs();
    wb_ex = 0; wb_bd = 0; wb_excode = 0; wb_pc = 0; wb_badvaddr = 0;
    eret_flush = 0; mtc0_we = 0; cp0_addr = 0; cp0_wdata = 0;
  endtask

  task automatic step();
    #1;
    check_eq("rdata", cp0_rdata, m_read(cp0_addr));
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic do_mtc0(input logic [7:0] a, input logic [31:0] d);
    idle_inputs(); mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
    step(); idle_inputs();
  endtask

  task automatic do_exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                        input logic [31:0] badv);
    idle_inputs(); wb_ex = 1; wb_excode = code; wb_bd = bd; wb_pc = pc; wb_badvaddr = badv;
    step(); idle_inputs();
  endtask

  task automatic do_eret();
    idle_inputs(); eret_flush = 1; step(); idle_inputs();
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cp0_addr = a; #1;
    check_eq(tag, cp0_rdata, exp);
  endtask

  logic [7:0] addr_tab [6] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70};

  initial begin
    idle_inputs();
    ext_int_in = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    check_outputs();
    check_eq("rst_epc", cp0_epc, EpcReset);
    read_check("rst_status", 8'h60, 32'h0040_0000);
    read_check("rst_cause", 8'h68, 32'h0000_0000);
    check_eq("rst_has_int", {31'd0, has_int}, 32'd0);
    idle_inputs();

    do_exc(5'h08, 1'b0, 32'hBFC0_0380, 32'd0);
    check_eq("sys_epc", cp0_epc, 32'hBFC0_0380);
    check_eq("sys_cause", cp0_cause & 32'h8000_007C, 32'h0000_0020);
    check_eq("sys_exl", {31'd0, cp0_status[1]}, 32'd1);
    do_eret();
    check_eq("eret_exl", {31'd0, cp0_status[1]}, 32'd0);

    do_exc(5'h08, 1'b0, 32'h0000_0000, 32'd0);
    do_exc(5'h0C, 1'b1, 32'h8000_0104, 32'd0);
    check_eq("exl_epc_hold", cp0_epc, 32'h0000_0000);
    check_eq("exl_cause", cp0_cause & 32'h8000_007C, 32'h0000_0030);
    do_eret();
    do_exc(5'h0C, 1'b1, 32'h8000_0104, 32'd0);
    check_eq("bd_epc", cp0_epc, 32'h8000_0100);
    check_eq("bd_cause", cp0_cause & 32'h8000_007C, 32'h8000_0030);
    do_exc(5'h04, 1'b0, 32'h0000_0040, 32'h1234_5679);
    read_check("badvaddr", 8'h40, 32'h1234_5679);
    idle_inputs();
    do_eret();

    do_mtc0(8'h58, 32'd5);
    do_mtc0(8'h48, 32'd0);
    repeat (10) step();
    read_check("count5", 8'h48, 32'd5);
    idle_inputs();
    repeat (2) step();
    check_eq("ti_ip7", cp0_cause & 32'h4000_8000, 32'h4000_8000);
    do_mtc0(8'h60, 32'h0040_8001);
    check_eq("timer_int", {31'd0, has_int}, 32'd1);
    do_mtc0(8'h58, 32'h0001_0000);
    step();
    check_eq("ti_clear", cp0_cause & 32'h4000_0000, 32'd0);
    check_eq("timer_int_clr", {31'd0, has_int}, 32'd0);

    ext_int_in = 6'b000001;
    do_mtc0(8'h60, 32'h0040_0401);
    step();
    check_eq("ip2", cp0_cause & 32'h0000_0400, 32'h0000_0400);
    check_eq("hw_int", {31'd0, has_int}, 32'd1);
    idle_inputs();
    wb_ex = 1; wb_excode = 5'h00; wb_pc = 32'h0000_1000;
    mtc0_we = 1; cp0_addr = 8'h70; cp0_wdata = 32'hDEAD_BEEF;
    step();
    check_eq("ex_beats_mtc0", cp0_epc, 32'h0000_1000);
    idle_inputs();
    do_eret();
    do_mtc0(8'h48, 32'hFFFF_FFFF);
    repeat (2) step();
    read_check("count_wrap", 8'h48, 32'd0);
    idle_inputs();
    ext_int_in = 0;

    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      idle_inputs();
      r = $urandom_range(0, 99);
      cp0_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : addr_tab[$urandom_range(0, 5)];
      if (r < 8) begin
        wb_ex = 1; wb_bd = 1'($urandom);
        wb_excode = ($urandom_range(0, 1) == 1) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom);
        wb_pc = $urandom; wb_badvaddr = $urandom;
        eret_flush = (r < 3);
      end else if (r < 14) begin
        eret_flush = 1;
      end
      if ($urandom_range(0, 3) == 0) begin
        mtc0_we = 1;
        cp0_wdata = $urandom;
        if (cp0_addr == 8'h58 && $urandom_range(0, 1) == 1)
          cp0_wdata = m_count + $urandom_range(0, 6);
      end
      if ($urandom_range(0, 15) == 0) ext_int_in = 6'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
